// File: rtl/cpu_tlb.sv
// Fully-associative data TLB with FIFO replacement, registered lookup response
// and a single-shot miss exception that re-arms on entry to supervisor mode.
module cpu_tlb #(
  parameter int ENTRIES     = 4,
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 20,
  parameter int PAGE_BITS   = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [VADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]            wr_data,
  input  logic                   flush,
  input  logic                   supervisor,
  input  logic                   lookup_valid,
  input  logic [VADDR_WIDTH-1:0] lookup_vaddr,
  input  logic [VADDR_WIDTH-1:0] lookup_pc,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [PADDR_WIDTH-1:0] resp_paddr,
  output logic                   exc_raise,
  output logic [VADDR_WIDTH-1:0] exc_pc,
  output logic [VADDR_WIDTH-1:0] exc_vaddr
);

  localparam int VPN_W = VADDR_WIDTH - PAGE_BITS;
  localparam int PPN_W = PADDR_WIDTH - PAGE_BITS;
  localparam int PTR_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0]   vpn_tab [ENTRIES];
  logic [PPN_W-1:0]   ppn_tab [ENTRIES];
  logic [PTR_W-1:0]   wr_ptr;
  logic               exc_pending;

  logic [VPN_W-1:0]       wr_vpn;
  logic [PPN_W-1:0]       wr_ppn;
  logic [VPN_W-1:0]       lk_vpn;
  logic                   lk_hit;
  logic [PPN_W-1:0]       lk_ppn;
  logic                   wr_hit;
  logic [PTR_W-1:0]       wr_idx;
  logic                   user_miss;
  logic                   raise_now;
  logic [PADDR_WIDTH-1:0] lk_paddr;
  logic                   unused_bits;

  assign wr_vpn      = wr_addr[VADDR_WIDTH-1:PAGE_BITS];
  assign wr_ppn      = wr_data[PADDR_WIDTH-1:PAGE_BITS];
  assign lk_vpn      = lookup_vaddr[VADDR_WIDTH-1:PAGE_BITS];
  assign unused_bits = ^{wr_data, wr_addr};

  // Parallel tag match for both the lookup port and the write port; the write
  // path never creates duplicate VPNs, so at most one entry matches each.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lk_hit = 1'b0;
    lk_ppn = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && vpn_tab[i] == lk_vpn) begin
        lk_hit = 1'b1;
        lk_ppn = ppn_tab[i];
      end
      if (valid[i] && vpn_tab[i] == wr_vpn) begin
        wr_hit = 1'b1;
        wr_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    lk_paddr = '0;
    if (supervisor)  lk_paddr = lookup_vaddr[PADDR_WIDTH-1:0];
    else if (lk_hit) lk_paddr = {lk_ppn, lookup_vaddr[PAGE_BITS-1:0]};
  end

  assign user_miss = lookup_valid && !supervisor && !lk_hit;
  assign raise_now = user_miss && !exc_pending;

  // Table update. Flush outranks a same-cycle write, which is dropped.
  always_ff @(posedge clock) begin
    // NOTE: only the valid bits and pointer are reset; tag/data arrays are don't-care while invalid.
    if (reset) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      if (wr_hit) begin
        ppn_tab[wr_idx] <= wr_ppn;
      end else begin
        vpn_tab[wr_ptr] <= wr_vpn;
        ppn_tab[wr_ptr] <= wr_ppn;
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
    end
  end

  // Registered response and exception record, valid the cycle after the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_paddr  <= '0;
      exc_raise   <= 1'b0;
      exc_pc      <= '0;
      exc_vaddr   <= '0;
      exc_pending <= 1'b0;
    end else begin
      resp_valid <= lookup_valid;
      resp_hit   <= lookup_valid && (supervisor || lk_hit);
      resp_paddr <= lookup_valid ? lk_paddr : '0;
      exc_raise  <= raise_now;
      if (raise_now) begin
        exc_pc    <= lookup_pc;
        exc_vaddr <= lookup_vaddr;
      end
      // Entering the handler (any supervisor cycle) re-arms the exception.
      if (supervisor)     exc_pending <= 1'b0;
      else if (raise_now) exc_pending <= 1'b1;
    end
  end

endmodule

// File: doc/cpu_tlb.md
# cpu_tlb

Fully-associative data TLB that responds to the decode stage's TLB-write requests and to per-access lookup requests from the memory stage. It translates virtual to physical addresses and raises the `tlb_exception` record (`raise`, `pc`, `vaddr`) that decode consumes. In supervisor mode (`rm4 = 1`) it bypasses translation. Lookups complete one cycle after they are presented; writes take effect on the next cycle.

## Interface
- Parameters:
  - `ENTRIES`, default 4: number of entries; must be a power of 2 and at least 2.
  - `VADDR_WIDTH`, default 32: virtual address width.
  - `PADDR_WIDTH`, default 20: physical address width.
  - `PAGE_BITS`, default 12: page offset width. VPN is `VADDR_WIDTH-PAGE_BITS` bits; PPN is `PADDR_WIDTH-PAGE_BITS` bits.
- Ports:
  - `clock` in 1: clock.
  - `reset` in 1: synchronous, active-high.
  - `wr_en` in 1: TLB write request (decode `tlb_write.enable`).
  - `wr_addr` in VADDR_WIDTH: virtual address to map; VPN = `wr_addr[VADDR_WIDTH-1:PAGE_BITS]`.
  - `wr_data` in 32: physical address; PPN = `wr_data[PADDR_WIDTH-1:PAGE_BITS]`.
  - `flush` in 1: invalidate all entries.
  - `supervisor` in 1: privileged mode (`rm4`); bypasses translation.
  - `lookup_valid` in 1: lookup request.
  - `lookup_vaddr` in VADDR_WIDTH: address to translate.
  - `lookup_pc` in VADDR_WIDTH: PC of the requesting instruction.
  - `resp_valid` out 1: response valid (one-cycle pulse).
  - `resp_hit` out 1: translation succeeded.
  - `resp_paddr` out PADDR_WIDTH: translated address.
  - `exc_raise` out 1: TLB-miss exception pulse.
  - `exc_pc` out VADDR_WIDTH: PC of the faulting access.
  - `exc_vaddr` out VADDR_WIDTH: faulting virtual address.

## Operation
- **State:** per entry, `valid`, `vpn` and `ppn`; a FIFO replacement pointer `wr_ptr` of `log2(ENTRIES)` bits; and an `exc_pending` flag.
- **Write, VPN already present:** overwrite that entry's PPN. `wr_ptr` is unchanged. No duplicate VPNs are ever created.
- **Write, VPN absent:** fill entry `wr_ptr`, set `valid`, then `wr_ptr <= wr_ptr+1`, wrapping modulo ENTRIES. The oldest fill is evicted whether or not it is valid.
- **Flush:** clear all `valid` bits and reset `wr_ptr` to 0.
  - Flush takes priority over a same-cycle `wr_en`; that write is dropped.
- **Lookup, supervisor:** `resp_hit = 1`, `resp_paddr = lookup_vaddr[PADDR_WIDTH-1:0]`, no exception.
- **Lookup, user:**
  - Compare the VPN against all valid entries in parallel.
  - On a hit: `resp_paddr = {ppn, lookup_vaddr[PAGE_BITS-1:0]}` and `resp_hit = 1`.
  - On a miss: `resp_hit = 0` and `resp_paddr = 0`.
- **Exception on a user miss:**
  - If `exc_pending = 0`: pulse `exc_raise`, latch `exc_pc` and `exc_vaddr`, and set `exc_pending`.
  - If `exc_pending = 1`: further misses still return `resp_hit = 0` but raise no exception. This suppresses shadow-instruction faults.
  - `exc_pending` clears on any cycle with `supervisor = 1`, i.e. after the handler is entered.
- **Write and lookup in the same cycle:** the lookup sees the pre-write contents.
- **Flush and lookup in the same cycle:** the lookup sees the pre-flush contents.

## Timing
- **Reset (synchronous):**
  - All `valid = 0`, `wr_ptr = 0`, `exc_pending = 0`.
  - `resp_valid`, `resp_hit`, `resp_paddr`, `exc_raise`, `exc_pc` and `exc_vaddr` are all 0.
  - Reset overrides any concurrent write, flush or lookup; no response is produced for a lookup presented in the reset cycle.
- **Lookup latency:** a request sampled at edge N produces `resp_*` and `exc_*` valid after edge N, for exactly one cycle.
- **Throughput:** one lookup per cycle, no stall and no backpressure.
- **Output hold:** `exc_pc` and `exc_vaddr` keep their last latched value until the next raise. `resp_paddr` and `resp_hit` are 0 whenever `resp_valid = 0`.
- **Write visibility:** a write sampled at edge N is visible to a lookup sampled at edge N+1 or later.

## Test plan
1. **Miss after reset.** Reset, then user lookup `vaddr=0x00001234`, `pc=0x00000040` → next cycle `resp_valid=1`, `resp_hit=0`, `exc_raise=1`, `exc_vaddr=0x00001234`, `exc_pc=0x00000040`.
2. **Write then hit.** Write `wr_addr=0x00005000`, `wr_data=0x0000A000`; next cycle user lookup `0x00005ABC` → `resp_hit=1`, `resp_paddr=0xAABC`, `exc_raise=0`.
3. **FIFO eviction.** Write VPNs 1,2,3,4,5 to PPNs 0x11..0x15 on consecutive cycles → lookup `0x00001000` misses; lookup `0x00005000` returns `0x15000`; `wr_ptr=1`.
4. **Rewrite in place.** After scenario 3, rewrite VPN 3 to PPN 0x33 → `wr_ptr` stays 1; lookup `0x00003010` returns `0x33010`; VPN 2 still hits.
5. **Supervisor and suppression.**
   - Supervisor lookup `0x12345678` → `resp_paddr=0x45678`, `resp_hit=1`, no exception.
   - Two consecutive user misses → exactly one `exc_raise`.
   - One cycle with `supervisor=1`, then a user miss → `exc_raise` pulses again.
6. **Flush collisions.**
   - `flush` together with `wr_en` for VPN 7 → VPN 7 misses afterwards and `wr_ptr=0`.
   - A lookup issued in the flush cycle against a previously valid entry still hits.
